// File: rtl/vj_pkg.sv
// rtl/vj_pkg.sv - shared coordinate widths, image defaults and box record for the VJ pipeline
package vj_pkg;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int CNT_W     = 5;
  localparam int IMG_W_DEF = 320;
  localparam int IMG_H_DEF = 240;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
  } box_t;

endpackage

// File: rtl/vj_box_hit.sv
// rtl/vj_box_hit.sv - combinational test of one pixel position against one box outline
module vj_box_hit
  import vj_pkg::*;
(
  input  box_t           box_i,
  input  logic [X_W-1:0] x_i,
  input  logic [Y_W-1:0] y_i,
  output logic           hit_o
);

  // 11-bit arithmetic so right/bottom edges past the image never wrap
  logic [10:0] bx, by, xr, yb, px, py;
  logic        on_row, on_col;

  assign bx = {1'b0, box_i.x};
  assign by = {2'b0, box_i.y};
  assign xr = bx + {1'b0, box_i.w} - 11'd1;
  assign yb = by + {2'b0, box_i.h} - 11'd1;
  assign px = {1'b0, x_i};
  assign py = {2'b0, y_i};

  assign on_row = (px >= bx) && (px <= xr) && ((py == by) || (py == yb));
  assign on_col = (py >= by) && (py <= yb) && ((px == bx) || (px == xr));
  assign hit_o  = on_row || on_col;

endmodule

// File: rtl/vj_bbox_overlay.sv
// rtl/vj_bbox_overlay.sv - collects detections into a ping-pong box table and outlines them on the next video frame
module vj_bbox_overlay
  import vj_pkg::*;
#(
  parameter int         IMG_W   = IMG_W_DEF,
  parameter int         IMG_H   = IMG_H_DEF,
  parameter int         MAX_DET = 8,
  parameter logic [7:0] BOX_VAL = 8'd255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_valid,
  input  logic [X_W-1:0]   det_x,
  input  logic [Y_W-1:0]   det_y,
  input  logic [X_W-1:0]   det_w,
  input  logic [Y_W-1:0]   det_h,
  input  logic             det_busy,
  input  logic             in_frame_start,
  input  logic             in_pixel_valid,
  input  logic [7:0]       in_pixel,
  output logic             out_frame_start,
  output logic             out_pixel_valid,
  output logic [7:0]       out_pixel,
  output logic             out_on_box,
  output logic [CNT_W-1:0] det_count,
  output logic             det_overflow
);

  localparam int IDX_W = (MAX_DET > 1) ? $clog2(MAX_DET) : 1;

  box_t             bank_q [2][MAX_DET];
  logic             wr_bank_q;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_ovf_q, wr_ovf_d;
  logic             pending_q, pending_d;
  logic             busy_q;
  logic [CNT_W-1:0] det_count_q;
  logic             det_ovf_q;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             ofs_q, ovalid_q, on_box_q;
  logic [7:0]       opix_q;

  logic             fall, swap, accept, store;
  logic             tgt_bank, act_bank;
  logic [CNT_W-1:0] base_cnt, act_cnt;
  logic             base_ovf;
  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic             in_img, any_hit;
  logic [MAX_DET-1:0] hit_vec;

  assign fall     = busy_q & ~det_busy;
  assign swap     = in_frame_start & pending_q;
  assign tgt_bank = swap ? ~wr_bank_q : wr_bank_q;
  assign base_cnt = swap ? '0 : wr_cnt_q;
  assign base_ovf = swap ? 1'b0 : wr_ovf_q;
  assign accept   = det_valid && (det_w != '0) && (det_h != '0);
  assign store    = accept && (base_cnt < CNT_W'(MAX_DET));

  // On a swap cycle the pixel being tested already belongs to the new frame
  assign act_bank = swap ? wr_bank_q : ~wr_bank_q;
  assign act_cnt  = swap ? wr_cnt_q : det_count_q;

  always_comb begin
    wr_cnt_d  = base_cnt + CNT_W'(store);
    wr_ovf_d  = base_ovf | (accept & ~store);
    pending_d = fall | (pending_q & ~swap);
  end

  assign cur_x  = in_frame_start ? '0 : x_q;
  assign cur_y  = in_frame_start ? '0 : y_q;
  assign in_img = cur_y < Y_W'(IMG_H);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (in_pixel_valid) begin
      x_d = cur_x;
      y_d = cur_y;
      if (in_img) begin
        if (cur_x == X_W'(IMG_W - 1)) begin
          x_d = '0;
          y_d = cur_y + 1'b1;
        end else begin
          x_d = cur_x + 1'b1;
        end
      end
    end else if (in_frame_start) begin
      x_d = '0;
      y_d = '0;
    end
  end

  for (genvar i = 0; i < MAX_DET; i++) begin : g_hit
    logic raw_hit;
    vj_box_hit u_hit (
      .box_i (bank_q[act_bank][i]),
      .x_i   (cur_x),
      .y_i   (cur_y),
      .hit_o (raw_hit)
    );
    assign hit_vec[i] = raw_hit & (CNT_W'(i) < act_cnt);
  end

  assign any_hit = (|hit_vec) & in_img;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < MAX_DET; i++)
          bank_q[b][i] <= '0;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      wr_ovf_q    <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      det_count_q <= '0;
      det_ovf_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      ofs_q       <= 1'b0;
      ovalid_q    <= 1'b0;
      opix_q      <= '0;
      on_box_q    <= 1'b0;
    end else begin
      if (store)
        bank_q[tgt_bank][base_cnt[IDX_W-1:0]] <= '{x: det_x, y: det_y, w: det_w, h: det_h};
      if (swap) begin
        det_count_q <= wr_cnt_q;
        det_ovf_q   <= wr_ovf_q;
        wr_bank_q   <= ~wr_bank_q;
      end
      wr_cnt_q  <= wr_cnt_d;
      wr_ovf_q  <= wr_ovf_d;
      pending_q <= pending_d;
      busy_q    <= det_busy;
      x_q       <= x_d;
      y_q       <= y_d;
      ofs_q     <= in_frame_start;
      ovalid_q  <= in_pixel_valid;
      on_box_q  <= in_pixel_valid & any_hit;
      if (in_pixel_valid)
        opix_q <= any_hit ? BOX_VAL : in_pixel;
    end
  end

  assign out_frame_start = ofs_q;
  assign out_pixel_valid = ovalid_q;
  assign out_pixel       = opix_q;
  assign out_on_box      = on_box_q;
  assign det_count       = det_count_q;
  assign det_overflow    = det_ovf_q;

endmodule

// File: tb/tb_vj_bbox_overlay.sv
// tb/tb_vj_bbox_overlay.sv - directed self-checking bench for vj_bbox_overlay on a reduced 40x30 image
module tb_vj_bbox_overlay;

  localparam int W = 40;
  localparam int H = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       det_valid = 1'b0;
  logic [9:0] det_x = '0;
  logic [8:0] det_y = '0;
  logic [9:0] det_w = '0;
  logic [8:0] det_h = '0;
  logic       det_busy = 1'b0;
  logic       in_frame_start = 1'b0;
  logic       in_pixel_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       out_frame_start, out_pixel_valid, out_on_box, det_overflow;
  logic [7:0] out_pixel;
  logic [4:0] det_count;

  int n_vec = 0;
  int n_bad = 0;

  int mbx[8], mby[8], mbw[8], mbh[8];
  int mn = 0;
  int mid_x, mid_y, mid_w, mid_h;

  always #5 clk = ~clk;

  vj_bbox_overlay #(.IMG_W(W), .IMG_H(H), .MAX_DET(8), .BOX_VAL(8'd255)) dut (
    .clk(clk), .reset(reset),
    .det_valid(det_valid), .det_x(det_x), .det_y(det_y), .det_w(det_w), .det_h(det_h),
    .det_busy(det_busy),
    .in_frame_start(in_frame_start), .in_pixel_valid(in_pixel_valid), .in_pixel(in_pixel),
    .out_frame_start(out_frame_start), .out_pixel_valid(out_pixel_valid),
    .out_pixel(out_pixel), .out_on_box(out_on_box),
    .det_count(det_count), .det_overflow(det_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit mhit(input int x, input int y);
    bit h = 0;
    for (int i = 0; i < mn; i++) begin
      int xr = mbx[i] + mbw[i] - 1;
      int yb = mby[i] + mbh[i] - 1;
      if ((x >= mbx[i] && x <= xr && (y == mby[i] || y == yb)) ||
          (y >= mby[i] && y <= yb && (x == mbx[i] || x == xr)))
        h = 1;
    end
    return h;
  endfunction

  function automatic void set_box(input int i, input int x, input int y, input int w, input int h);
    mbx[i] = x; mby[i] = y; mbw[i] = w; mbh[i] = h;
  endfunction

  task automatic send_det(input int x, input int y, input int w, input int h);
    det_valid = 1'b1;
    det_x = 10'(x); det_y = 9'(y); det_w = 10'(w); det_h = 9'(h);
    step();
    det_valid = 1'b0;
  endtask

  task automatic commit();
    det_busy = 1'b0;
    step();
    step();
  endtask

  task automatic run_frame(input string tag, input int exp_on, input int exp_cnt,
                           input int exp_ovf, input int mid_at, input int rst_at);
    int  errs = 0;
    int  on = 0;
    bit  eh;
    logic [7:0] val = 8'h40;
    logic [7:0] ep;
    in_frame_start = 1'b1;
    in_pixel_valid = 1'b0;
    step();
    in_frame_start = 1'b0;
    chk({tag, "_fs"}, 32'(out_frame_start), 1);
    chk({tag, "_cnt"}, 32'(det_count), 32'(exp_cnt));
    chk({tag, "_ovf"}, 32'(det_overflow), 32'(exp_ovf));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int p = y * W + x;
        if (p == rst_at) begin
          reset = 1'b1;
          #1;
          chk({tag, "_rst_out"},
              {16'd0, out_frame_start, out_pixel_valid, out_pixel, out_on_box, det_count, det_overflow}, 0);
          step();
          in_pixel_valid = 1'b0;
          det_busy = 1'b0;
          step();
          reset = 1'b0;
          step();
          return;
        end
        if (p == mid_at) begin
          det_valid = 1'b1;
          det_x = 10'(mid_x); det_y = 9'(mid_y); det_w = 10'(mid_w); det_h = 9'(mid_h);
          det_busy = 1'b0;
        end
        in_pixel_valid = 1'b1;
        in_pixel = val;
        step();
        det_valid = 1'b0;
        eh = mhit(x, y);
        ep = eh ? 8'd255 : val;
        if (out_pixel !== ep || out_pixel_valid !== 1'b1 || out_on_box !== eh) errs++;
        if (out_on_box === 1'b1) on++;
      end
    end
    for (int k = 0; k < 2; k++) begin
      step();
      if (out_pixel !== val || out_on_box !== 1'b0) errs++;
    end
    in_pixel_valid = 1'b0;
    step();
    chk({tag, "_idle"}, {22'd0, out_pixel_valid, out_on_box, out_pixel}, {24'd0, val});
    chk({tag, "_pixerr"}, 32'(errs), 0);
    chk({tag, "_onbox"}, 32'(on), 32'(exp_on));
  endtask

  initial begin
    step();
    step();
    chk("reset_out",
        {16'd0, out_frame_start, out_pixel_valid, out_pixel, out_on_box, det_count, det_overflow}, 0);
    reset = 1'b0;
    step();

    // single box
    det_busy = 1'b1; step();
    send_det(10, 20, 5, 4);
    commit();
    mn = 1; set_box(0, 10, 20, 5, 4);
    run_frame("single", 14, 1, 0, -1, -1);

    // commit lands mid-frame; current frame keeps the old box
    det_busy = 1'b1; step();
    mid_x = 2; mid_y = 3; mid_w = 4; mid_h = 4;
    run_frame("midfr", 14, 1, 0, 600, -1);
    mn = 1; set_box(0, 2, 3, 4, 4);
    run_frame("nextfr", 12, 1, 0, -1, -1);

    // nine detections into an eight-deep bank
    det_busy = 1'b1; step();
    for (int i = 0; i < 9; i++) send_det(i * 4, 0, 1, 1);
    commit();
    mn = 8;
    for (int i = 0; i < 8; i++) set_box(i, i * 4, 0, 1, 1);
    run_frame("ovf", 8, 8, 1, -1, -1);

    // zero-width detection is ignored
    det_busy = 1'b1; step();
    send_det(5, 5, 0, 3);
    commit();
    mn = 0;
    run_frame("zerow", 0, 0, 0, -1, -1);

    // box clipped at the bottom-right corner
    det_busy = 1'b1; step();
    send_det(35, 25, 10, 10);
    commit();
    mn = 1; set_box(0, 35, 25, 10, 10);
    run_frame("edge", 9, 1, 0, -1, -1);

    // reset in the middle of streaming with a commit pending
    det_busy = 1'b1; step();
    send_det(0, 0, 4, 4);
    commit();
    det_busy = 1'b1; step();
    mn = 1; set_box(0, 0, 0, 4, 4);
    mid_x = 1; mid_y = 1; mid_w = 3; mid_h = 3;
    run_frame("rstfr", 0, 1, 0, 100, 300);
    chk("post_rst_cnt", 32'(det_count), 0);
    mn = 0;
    run_frame("afterrst", 0, 0, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
